onewire_txn_controller: RTL

- Byte/transaction-level sequencer for the 1-Wire bit timing engine.
- Accepts one request at a time from the host side: bus reset with presence detect, write byte, or read byte.
- Expands each request into a sequence of bit-level commands (RESET, PRESENCE, WRITE, READ) using a start/done handshake with the engine.
- Returns read data, the presence flag and an error flag through a valid/ready response port.

---
 rtl/onewire_pkg.sv | 24 ++
 rtl/onewire_timeout_timer.sv | 35 +++
 rtl/onewire_txn_controller.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/onewire_pkg.sv
// Shared encodings for the 1-Wire transaction controller: bit-engine commands,
// host request ops and controller FSM states.
package onewire_pkg;

    localparam logic [1:0] BC_WRITE    = 2'b00;
    localparam logic [1:0] BC_READ     = 2'b01;
    localparam logic [1:0] BC_RESET    = 2'b10;
    localparam logic [1:0] BC_PRESENCE = 2'b11;

    localparam logic [1:0] OP_WRITE_BYTE = 2'b00;
    localparam logic [1:0] OP_READ_BYTE  = 2'b01;
    localparam logic [1:0] OP_BUS_RESET  = 2'b10;
    localparam logic [1:0] OP_ILLEGAL    = 2'b11;

    localparam int unsigned DEF_BUS_TIMEOUT = 4095;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/onewire_timeout_timer.sv
// Per-bit watchdog: counts enabled cycles since the last clear and flags expiry
// on the BUS_TIMEOUT-th enabled cycle, saturating there.
module onewire_timeout_timer #(
    parameter int unsigned BUS_TIMEOUT = 4095,
    parameter int unsigned TO_W        = 12
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    logic [TO_W-1:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q >= TO_W'(BUS_TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/onewire_txn_controller.sv
// Byte-level 1-Wire sequencer: expands host requests into RESET/PRESENCE/WRITE/READ
// bit commands for the timing engine and returns the result on a valid/ready port.
module onewire_txn_controller
    import onewire_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = DEF_BUS_TIMEOUT,
    parameter int unsigned TO_W        = 12
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [1:0] req_op_i,
    input  logic [7:0] req_wdata_i,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic [7:0] rsp_rdata_o,
    output logic       rsp_presence_o,
    output logic       rsp_error_o,
    output logic [1:0] bit_cmd_o,
    output logic       bit_wdata_o,
    output logic       bit_start_o,
    input  logic       bit_done_i,
    input  logic       bit_rdata_i,
    output logic       busy_o
);

    state_e     state_q, state_d;
    logic [1:0] op_q, op_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       presence_q, presence_d;
    logic       error_q, error_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       timeout_expired;
    logic       last_bit;

    onewire_timeout_timer #(
        .BUS_TIMEOUT (BUS_TIMEOUT),
        .TO_W        (TO_W)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (state_q == ISSUE),
        .en_i      (state_q == WAIT),
        .expired_o (timeout_expired)
    );

    // A bus reset is only two commands long; bytes run the full 8.
    assign last_bit = (op_q == OP_BUS_RESET) ? (bit_cnt_q == 3'd1) : (bit_cnt_q == 3'd7);

    always_comb begin
        case (op_q)
            OP_BUS_RESET: bit_cmd_o = (bit_cnt_q == 3'd0) ? BC_RESET : BC_PRESENCE;
            OP_READ_BYTE: bit_cmd_o = BC_READ;
            default:      bit_cmd_o = BC_WRITE;
        endcase
    end

    assign bit_wdata_o    = (op_q == OP_WRITE_BYTE) && wdata_q[bit_cnt_q];
    assign bit_start_o    = (state_q == ISSUE);
    assign req_ready_o    = (state_q == IDLE);
    assign busy_o         = (state_q != IDLE);
    assign rsp_valid_o    = (state_q == RESP);
    assign rsp_rdata_o    = rdata_q;
    assign rsp_presence_o = presence_q;
    assign rsp_error_o    = error_q;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        presence_d = presence_q;
        error_d    = error_q;
        bit_cnt_d  = bit_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    rdata_d    = 8'h00;
                    presence_d = 1'b0;
                    error_d    = 1'b0;
                    bit_cnt_d  = 3'd0;
                    if (req_op_i == OP_ILLEGAL) begin
                        error_d = 1'b1;
                        state_d = RESP;
                    end else begin
                        op_d    = req_op_i;
                        wdata_d = req_wdata_i;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                // bit_done takes priority over a timeout expiring in the same cycle.
                if (bit_done_i) begin
                    if (op_q == OP_READ_BYTE) begin
                        rdata_d[bit_cnt_q] = bit_rdata_i;
                    end
                    if (op_q == OP_BUS_RESET && last_bit) begin
                        presence_d = ~bit_rdata_i;
                    end
                    if (last_bit) begin
                        state_d = RESP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        state_d   = ISSUE;
                    end
                end else if (timeout_expired) begin
                    error_d = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            op_q       <= 2'b00;
            wdata_q    <= 8'h00;
            rdata_q    <= 8'h00;
            presence_q <= 1'b0;
            error_q    <= 1'b0;
            bit_cnt_q  <= 3'd0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            presence_q <= presence_d;
            error_q    <= error_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

endmodule
